// File: rtl/comb_mc_if.sv
// rtl/comb_mc_if.sv - sample stream bundle for the multi-channel CIC comb stage
interface comb_mc_if #(
    parameter int SAMP_WIDTH = 18,
    parameter int OUT_WIDTH  = 18,
    parameter int CH_W       = 2
);
    logic signed [SAMP_WIDTH-1:0] samp_inp_data;
    logic        [CH_W-1:0]       samp_inp_chan;
    logic                         samp_inp_str;
    logic                         flush;
    logic signed [OUT_WIDTH-1:0]  samp_out_data;
    logic        [CH_W-1:0]       samp_out_chan;
    logic                         samp_out_str;
    logic                         chan_err;

    modport master (
        output samp_inp_data, samp_inp_chan, samp_inp_str, flush,
        input  samp_out_data, samp_out_chan, samp_out_str, chan_err
    );

    modport slave (
        input  samp_inp_data, samp_inp_chan, samp_inp_str, flush,
        output samp_out_data, samp_out_chan, samp_out_str, chan_err
    );
endinterface

// File: rtl/comb_mc.sv
// rtl/comb_mc.sv - time-multiplexed CIC comb: y[n] = x[n] - x[n-M] per channel, with output pruning
module comb_mc #(
    parameter int SAMP_WIDTH = 18,
    parameter int OUT_WIDTH  = 18,
    parameter int CIC_M      = 1,
    parameter int CIC_CH     = 4,
    parameter int ROUND      = 0
) (
    input  logic      clk,
    input  logic      reset_n,
    comb_mc_if.slave  bus
);
    localparam int DROP = SAMP_WIDTH - OUT_WIDTH;
    localparam int PW   = (CIC_M > 1) ? $clog2(CIC_M) : 1;
    localparam int CH_W = (CIC_CH > 1) ? $clog2(CIC_CH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(CIC_M - 1);

    logic [SAMP_WIDTH-1:0] hist [CIC_CH][CIC_M];
    logic [PW-1:0]         ptr  [CIC_CH];

    logic                  in_range;
    logic                  accept;
    logic                  reject;
    logic [SAMP_WIDTH-1:0] old;
    logic [SAMP_WIDTH-1:0] diff;

    logic                  s1_vld;
    logic [SAMP_WIDTH-1:0] s1_diff;
    logic [CH_W-1:0]       s1_chan;
    logic [OUT_WIDTH-1:0]  pruned;

    assign in_range = 32'(bus.samp_inp_chan) < CIC_CH;
    assign accept   = bus.samp_inp_str & ~bus.flush & in_range;
    assign reject   = bus.samp_inp_str & ~bus.flush & ~in_range;

    // Read-before-write: the history slot about to be overwritten holds x[n-M].
    always_comb begin
        old = '0;
        for (int c = 0; c < CIC_CH; c++) begin
            if (bus.samp_inp_chan == CH_W'(c)) begin
                old = hist[c][ptr[c]];
            end
        end
    end

    assign diff = bus.samp_inp_data - old;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CIC_CH; c++) begin
                ptr[c] <= '0;
                for (int k = 0; k < CIC_M; k++) begin
                    hist[c][k] <= '0;
                end
            end
        end else if (bus.flush) begin
            for (int c = 0; c < CIC_CH; c++) begin
                ptr[c] <= '0;
                for (int k = 0; k < CIC_M; k++) begin
                    hist[c][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int c = 0; c < CIC_CH; c++) begin
                if (bus.samp_inp_chan == CH_W'(c)) begin
                    hist[c][ptr[c]] <= bus.samp_inp_data;
                    ptr[c]          <= (ptr[c] == PTR_LAST) ? '0 : ptr[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld       <= 1'b0;
            s1_diff      <= '0;
            s1_chan      <= '0;
            bus.chan_err <= 1'b0;
        end else begin
            s1_vld       <= accept;
            bus.chan_err <= reject;
            if (accept) begin
                s1_diff <= diff;
                s1_chan <= bus.samp_inp_chan;
            end
        end
    end

    generate
        if (DROP == 0) begin : g_full
            assign pruned = s1_diff;
        end else begin : g_prune
            // Bias by half an output LSB for round-half-up; the sum wraps in SAMP_WIDTH bits.
            localparam logic [SAMP_WIDTH-1:0] HALF =
                (ROUND != 0) ? (SAMP_WIDTH'(1) << (DROP - 1)) : '0;
            logic [SAMP_WIDTH-1:0] biased;
            assign biased = s1_diff + HALF;
            assign pruned = biased[SAMP_WIDTH-1:DROP];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.samp_out_str  <= 1'b0;
            bus.samp_out_data <= '0;
            bus.samp_out_chan <= '0;
        end else begin
            bus.samp_out_str <= s1_vld;
            if (s1_vld) begin
                bus.samp_out_data <= pruned;
                bus.samp_out_chan <= s1_chan;
            end
        end
    end
endmodule

// File: tb/tb_comb_mc.sv
// tb/tb_comb_mc.sv - randomized bench for comb_mc against a per-channel sample-log model
module tb_comb_mc;
    localparam int SW = 10;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [SW-1:0] in_data = '0;
    logic [1:0]    in_chan = '0;
    logic          in_str = 1'b0;
    logic          in_flush = 1'b0;

    always #5 clk = ~clk;

    comb_mc_if #(.SAMP_WIDTH(SW), .OUT_WIDTH(8),  .CH_W(2)) if_a ();
    comb_mc_if #(.SAMP_WIDTH(SW), .OUT_WIDTH(8),  .CH_W(2)) if_b ();
    comb_mc_if #(.SAMP_WIDTH(SW), .OUT_WIDTH(10), .CH_W(2)) if_c ();

    assign if_a.samp_inp_data = in_data;
    assign if_a.samp_inp_chan = in_chan;
    assign if_a.samp_inp_str  = in_str;
    assign if_a.flush         = in_flush;
    assign if_b.samp_inp_data = in_data;
    assign if_b.samp_inp_chan = in_chan;
    assign if_b.samp_inp_str  = in_str;
    assign if_b.flush         = in_flush;
    assign if_c.samp_inp_data = in_data;
    assign if_c.samp_inp_chan = in_chan;
    assign if_c.samp_inp_str  = in_str;
    assign if_c.flush         = in_flush;

    comb_mc #(.SAMP_WIDTH(SW), .OUT_WIDTH(8), .CIC_M(2), .CIC_CH(3), .ROUND(1))
        u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    comb_mc #(.SAMP_WIDTH(SW), .OUT_WIDTH(8), .CIC_M(1), .CIC_CH(3), .ROUND(0))
        u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
    comb_mc #(.SAMP_WIDTH(SW), .OUT_WIDTH(10), .CIC_M(3), .CIC_CH(4), .ROUND(0))
        u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

    logic [9:0] od [NI];
    logic [1:0] oc [NI];
    logic       os [NI];
    logic       oe [NI];

    assign od[0] = 10'(if_a.samp_out_data);
    assign od[1] = 10'(if_b.samp_out_data);
    assign od[2] = if_c.samp_out_data;
    assign oc[0] = if_a.samp_out_chan;
    assign oc[1] = if_b.samp_out_chan;
    assign oc[2] = if_c.samp_out_chan;
    assign os[0] = if_a.samp_out_str;
    assign os[1] = if_b.samp_out_str;
    assign os[2] = if_c.samp_out_str;
    assign oe[0] = if_a.chan_err;
    assign oe[1] = if_b.chan_err;
    assign oe[2] = if_c.chan_err;

    function automatic int m_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 3;
    endfunction
    function automatic int ch_of(int i);
        return (i == 2) ? 4 : 3;
    endfunction
    function automatic int ow_of(int i);
        return (i == 2) ? 10 : 8;
    endfunction
    function automatic int rnd_of(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Model state: every accepted sample per channel since the last flush/reset.
    int logs [NI][4][$];
    bit pv [NI];
    int pd [NI];
    int pc [NI];
    bit es [NI];
    int hd [NI];
    int hc [NI];
    bit ee [NI];

    int checks = 0;
    int failures = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int prune(int i, int d);
        int drop;
        int v;
        drop = SW - ow_of(i);
        v = d;
        if (rnd_of(i) != 0 && drop > 0) v = (v + (1 << (drop - 1))) % 1024;
        if (v >= 512) v = v - 1024;
        v = v >>> drop;
        return v & ((1 << ow_of(i)) - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < 4; c++) logs[i][c].delete();
            pv[i] = 0; pd[i] = 0; pc[i] = 0;
            es[i] = 0; hd[i] = 0; hc[i] = 0; ee[i] = 0;
        end
    endtask

    task automatic check_outputs(string pfx);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_str%0d", pfx, i), 32'(os[i]), 32'(es[i]));
            chk($sformatf("%s_err%0d", pfx, i), 32'(oe[i]), 32'(ee[i]));
            chk($sformatf("%s_data%0d", pfx, i), 32'(od[i]) & ((1 << ow_of(i)) - 1), hd[i]);
            chk($sformatf("%s_chan%0d", pfx, i), 32'(oc[i]), hc[i]);
        end
    endtask

    task automatic step(bit str, int chan, int data, bit fl);
        bit nv;
        bit err;
        int nd;
        int n;
        int old;
        in_str   = str;
        in_chan  = chan[1:0];
        in_data  = data[SW-1:0];
        in_flush = fl;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            nv = 0; err = 0; nd = 0;
            if (str && !fl) begin
                if (chan < ch_of(i)) begin
                    n   = logs[i][chan].size();
                    old = (n >= m_of(i)) ? logs[i][chan][n - m_of(i)] : 0;
                    logs[i][chan].push_back(data & 1023);
                    nv = 1;
                    nd = prune(i, (data - old) & 1023);
                end else begin
                    err = 1;
                end
            end
            if (fl) for (int c = 0; c < 4; c++) logs[i][c].delete();
            es[i] = pv[i];
            if (pv[i]) begin
                hd[i] = pd[i];
                hc[i] = pc[i];
            end
            pv[i] = nv; pd[i] = nd; pc[i] = chan; ee[i] = err;
        end
        @(negedge clk);
        check_outputs("run");
    endtask

    task automatic mid_reset();
        in_str = 1'b0;
        in_flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    int seq_ch [6] = '{0, 1, 0, 1, 0, 1};
    int seq_dt [6] = '{10, 100, 20, 300, 25, 350};

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        reset_n = 1'b1;

        step(1, 0, 5, 0); step(1, 0, 7, 0); step(1, 0, 3, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(1, seq_ch[k], seq_dt[k], 0);
        step(1, 1, 511, 0); step(1, 1, -512, 0);
        step(1, 2, 6, 0); step(1, 2, 13, 0); step(1, 2, 7, 0);
        step(1, 3, 77, 0); step(1, 0, 40, 0); step(1, 3, 1, 0); step(1, 3, 2, 0);
        step(1, 0, 50, 0); step(1, 0, 50, 0); step(1, 0, 50, 0);
        step(1, 0, 60, 1); step(1, 0, 70, 0); step(1, 3, 9, 1);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(1, 1, 123, 0); step(1, 2, 45, 0);
        mid_reset();
        step(0, 0, 0, 0); step(0, 0, 0, 0);

        for (int k = 0; k < 1500; k++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? ((k % 2 == 0) ? 511 : -512) : int'($urandom_range(0, 1023));
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), d, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) mid_reset();
        end
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
